// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter that shares one single-port synchronous RAM between NUM_PORTS cores.
// Optional macro ARB_BROADCAST_EN merges identical pure reads into one multi-hot grant.
module mem_arbiter_rr #(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int RD_LAT    = 1
) (
    input  logic                          CLK,
    input  logic                          rst_n,
    input  logic [NUM_PORTS-1:0]          rden,
    input  logic [NUM_PORTS-1:0]          wren,
    input  logic [NUM_PORTS*ADDR_W-1:0]   Address,
    input  logic [NUM_PORTS*DATA_W-1:0]   Din,
    input  logic [DATA_W-1:0]             RAMq,
    output logic [NUM_PORTS-1:0]          acq,
    output logic [NUM_PORTS*DATA_W-1:0]   Dq,
    output logic [NUM_PORTS-1:0]          rvalid,
    output logic [ADDR_W-1:0]             RAMAddress,
    output logic [DATA_W-1:0]             RAMDin,
    output logic                          RAMwren,
    output logic                          busy
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int DEPTH = RD_LAT + 1;

    logic [ADDR_W-1:0]    port_addr [NUM_PORTS];
    logic [DATA_W-1:0]    port_din  [NUM_PORTS];
    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] eligible;
    logic [NUM_PORTS-1:0] pure_read;
    logic [NUM_PORTS-1:0] grant;
    logic [PTR_W-1:0]     ptr;
    logic [PTR_W-1:0]     ptr_next;
    logic [PTR_W-1:0]     win;
    logic                 found;
    logic                 pipe_any;

    // Each slot carries a port mask so merged broadcast reads share one entry.
    logic [NUM_PORTS-1:0] pipe_mask [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
            assign port_addr[gi] = Address[gi*ADDR_W +: ADDR_W];
            assign port_din[gi]  = Din[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign req       = rden | wren;
    assign pure_read = rden & ~wren;
    // A port acknowledged this cycle may still show its request; never grant it twice.
    assign eligible  = req & ~acq;

    function automatic logic [PTR_W-1:0] rot(input logic [PTR_W-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_PORTS) begin
            sum = sum - NUM_PORTS;
        end
        return PTR_W'(sum);
    endfunction

    always_comb begin : pick_winner
        logic [PTR_W-1:0] idx;
        idx   = '0;
        found = 1'b0;
        win   = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            idx = rot(ptr, o);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin : build_grant
        grant    = '0;
        ptr_next = ptr;
        if (found) begin
            grant[win] = 1'b1;
            ptr_next   = rot(win, 1);
`ifdef ARB_BROADCAST_EN
            if (pure_read[win]) begin : merge_reads
                logic [PTR_W-1:0] idx;
                idx = '0;
                // Scanning in rotation order leaves ptr_next just past the last merged port.
                for (int o = 0; o < NUM_PORTS; o++) begin
                    idx = rot(ptr, o);
                    if (eligible[idx] && pure_read[idx] && (port_addr[idx] == port_addr[win])) begin
                        grant[idx] = 1'b1;
                        ptr_next   = rot(idx, 1);
                    end
                end
            end
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            acq        <= '0;
            RAMwren    <= 1'b0;
            RAMAddress <= '0;
            RAMDin     <= '0;
            ptr        <= '0;
        end else begin
            acq     <= grant;
            RAMwren <= found & wren[win];
            ptr     <= ptr_next;
            if (found) begin
                RAMAddress <= port_addr[win];
                RAMDin     <= port_din[win];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            for (int j = 0; j < DEPTH; j++) begin
                pipe_mask[j] <= '0;
            end
            rvalid <= '0;
            Dq     <= '0;
        end else begin
            pipe_mask[0] <= grant & pure_read;
            for (int j = 1; j < DEPTH; j++) begin
                pipe_mask[j] <= pipe_mask[j-1];
            end
            rvalid <= pipe_mask[DEPTH-1];
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (pipe_mask[DEPTH-1][i]) begin
                    Dq[i*DATA_W +: DATA_W] <= RAMq;
                end
            end
        end
    end

    always_comb begin
        pipe_any = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
            pipe_any = pipe_any | (|pipe_mask[j]);
        end
    end

    assign busy = (|req) | pipe_any | RAMwren;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench for mem_arbiter_rr with a one-cycle-latency RAM model.
module tb_mem_arbiter_rr;

    localparam int NP  = 3;
    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int LAT = 1;

    logic             CLK = 1'b0;
    logic             rst_n;
    logic [NP-1:0]    rden;
    logic [NP-1:0]    wren;
    logic [NP*AW-1:0] Address;
    logic [NP*DW-1:0] Din;
    logic [DW-1:0]    RAMq;
    logic [NP-1:0]    acq;
    logic [NP*DW-1:0] Dq;
    logic [NP-1:0]    rvalid;
    logic [AW-1:0]    RAMAddress;
    logic [DW-1:0]    RAMDin;
    logic             RAMwren;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;
    bit auto_drop = 1'b0;
    int grant_count [NP];

    always #5 CLK = ~CLK;

    mem_arbiter_rr #(
        .NUM_PORTS(NP),
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .RD_LAT   (LAT)
    ) dut (
        .CLK       (CLK),
        .rst_n     (rst_n),
        .rden      (rden),
        .wren      (wren),
        .Address   (Address),
        .Din       (Din),
        .RAMq      (RAMq),
        .acq       (acq),
        .Dq        (Dq),
        .rvalid    (rvalid),
        .RAMAddress(RAMAddress),
        .RAMDin    (RAMDin),
        .RAMwren   (RAMwren),
        .busy      (busy)
    );

    // RAM model: address registered on the edge, q valid the next cycle.
    logic [DW-1:0] ram [256];
    logic [255:0]  ram_written;
    logic [AW-1:0] ram_rd_addr;

    function automatic logic [DW-1:0] preload(input logic [AW-1:0] a);
        case (a)
            8'h2A:   return 8'h5C;
            8'h33:   return 8'h99;
            default: return ~a;
        endcase
    endfunction

    always @(posedge CLK) begin
        if (RAMwren) begin
            ram[RAMAddress]         <= RAMDin;
            ram_written[RAMAddress] <= 1'b1;
        end
        ram_rd_addr <= RAMAddress;
    end

    assign RAMq = (ram_written[ram_rd_addr] === 1'b1) ? ram[ram_rd_addr] : preload(ram_rd_addr);

    function automatic logic [DW-1:0] dq_of(input int p);
        return Dq[p*DW +: DW];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int port, input logic rd, input logic wr,
                                 input logic [AW-1:0] addr, input logic [DW-1:0] data);
        rden[port]            = rd;
        wren[port]            = wr;
        Address[port*AW +: AW] = addr;
        Din[port*DW +: DW]     = data;
    endtask

    // Advance one cycle; with auto_drop a port releases its request the cycle after its acq.
    task automatic tick();
        logic [NP-1:0] seen;
        seen = acq;
        @(posedge CLK);
        #1;
        if (auto_drop) begin
            rden = rden & ~seen;
            wren = wren & ~seen;
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        rden    = '1;
        wren    = '0;
        Address = {8'h03, 8'h02, 8'h01};
        Din     = '0;
        for (int i = 0; i < NP; i++) grant_count[i] = 0;

        // Reset with every port requesting
        repeat (3) tick();
        checkOutput("reset_acq", acq, 0);
        checkOutput("reset_ramwren", RAMwren, 0);
        checkOutput("reset_rvalid", rvalid, 0);
        checkOutput("reset_busy", busy, 1);
        checkOutput("reset_dq", Dq, 0);
        checkOutput("reset_ramaddr", RAMAddress, 0);

        auto_drop = 1'b1;
        rst_n     = 1'b1;
        tick();
        checkOutput("first_grant", acq, 3'b001);
        checkOutput("first_addr", RAMAddress, 8'h01);
        tick();
        checkOutput("second_grant", acq, 3'b010);
        tick();
        checkOutput("third_grant", acq, 3'b100);
        checkOutput("first_rvalid", rvalid, 3'b001);
        checkOutput("first_dq0", dq_of(0), 8'hFE);
        repeat (4) tick();
        checkOutput("idle_acq", acq, 0);
        checkOutput("idle_busy", busy, 0);

        // Single read by port 1
        applyStimulus(1, 1'b1, 1'b0, 8'h2A, 8'h00);
        tick();
        checkOutput("rd_acq", acq, 3'b010);
        checkOutput("rd_ramaddr", RAMAddress, 8'h2A);
        checkOutput("rd_ramwren", RAMwren, 0);
        tick();
        checkOutput("rd_no_double_grant", acq, 0);
        checkOutput("rd_rvalid_early", rvalid, 0);
        tick();
        checkOutput("rd_rvalid", rvalid, 3'b010);
        checkOutput("rd_dq1", dq_of(1), 8'h5C);
        checkOutput("rd_dq0_untouched", dq_of(0), 8'hFE);
        tick();
        checkOutput("rd_rvalid_pulse", rvalid, 0);
        checkOutput("rd_dq1_hold", dq_of(1), 8'h5C);

        // Write by port 2, then read back through port 0
        applyStimulus(2, 1'b0, 1'b1, 8'h10, 8'hA7);
        tick();
        checkOutput("wr_acq", acq, 3'b100);
        checkOutput("wr_ramwren", RAMwren, 1);
        checkOutput("wr_ramaddr", RAMAddress, 8'h10);
        checkOutput("wr_ramdin", RAMDin, 8'hA7);
        tick();
        checkOutput("wr_ramwren_off", RAMwren, 0);
        tick();
        checkOutput("wr_no_rvalid_a", rvalid, 0);
        tick();
        checkOutput("wr_no_rvalid_b", rvalid, 0);
        checkOutput("wr_idle_busy", busy, 0);
        applyStimulus(0, 1'b1, 1'b0, 8'h10, 8'h00);
        tick();
        checkOutput("rb_acq", acq, 3'b001);
        tick();
        tick();
        checkOutput("rb_rvalid", rvalid, 3'b001);
        checkOutput("rb_dq0", dq_of(0), 8'hA7);
        checkOutput("rb_dq2_untouched", dq_of(2), 8'hFC);

        // Fairness: all ports reading continuously, pointer currently at port 1
        auto_drop = 1'b0;
        applyStimulus(0, 1'b1, 1'b0, 8'h40, 8'h00);
        applyStimulus(1, 1'b1, 1'b0, 8'h41, 8'h00);
        applyStimulus(2, 1'b1, 1'b0, 8'h42, 8'h00);
        for (int i = 0; i < 12; i++) begin
            logic [NP-1:0] exp_acq;
            tick();
            exp_acq = 3'b001 << ((1 + i) % NP);
            checkOutput($sformatf("rotation_%0d", i), acq, exp_acq);
            for (int p = 0; p < NP; p++) begin
                if (acq[p]) grant_count[p]++;
            end
        end
        for (int p = 0; p < NP; p++) begin
            checkOutput($sformatf("grant_count_%0d", p), grant_count[p], 4);
        end
        rden = '0;
        repeat (4) tick();

        // Identical reads from all ports
        auto_drop = 1'b1;
        applyStimulus(0, 1'b1, 1'b0, 8'h33, 8'h00);
        applyStimulus(1, 1'b1, 1'b0, 8'h33, 8'h00);
        applyStimulus(2, 1'b1, 1'b0, 8'h33, 8'h00);
`ifdef ARB_BROADCAST_EN
        tick();
        checkOutput("bc_acq", acq, 3'b111);
        tick();
        checkOutput("bc_acq_done", acq, 0);
        tick();
        checkOutput("bc_rvalid", rvalid, 3'b111);
`else
        tick();
        checkOutput("ser_acq_a", acq, 3'b010);
        tick();
        checkOutput("ser_acq_b", acq, 3'b100);
        tick();
        checkOutput("ser_acq_c", acq, 3'b001);
        checkOutput("ser_rvalid_a", rvalid, 3'b010);
        tick();
        checkOutput("ser_acq_done", acq, 0);
        checkOutput("ser_rvalid_b", rvalid, 3'b100);
        tick();
        checkOutput("ser_rvalid_c", rvalid, 3'b001);
`endif
        checkOutput("bc_dq0", dq_of(0), 8'h99);
        checkOutput("bc_dq1", dq_of(1), 8'h99);
        checkOutput("bc_dq2", dq_of(2), 8'h99);
        repeat (3) tick();

        // Reset while a read is in flight
        applyStimulus(2, 1'b1, 1'b0, 8'h2A, 8'h00);
        tick();
        checkOutput("rst_rd_acq", acq, 3'b100);
        rst_n = 1'b0;
        tick();
        checkOutput("rst_rd_acq_cleared", acq, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput($sformatf("rst_rd_no_rvalid_%0d", i), rvalid, 0);
        end
        checkOutput("rst_rd_dq", Dq, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
